// File: rtl/ram_array_pkg.sv
// Shared types for the self-clearing synchronous memory array.
package ram_array_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

endpackage

// File: rtl/ram_core.sv
// Plain WIDTH x DEPTH register array: one synchronous write port, one registered read port.
module ram_core #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage carries no reset; the owner zeroes it by sweeping the write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/ram_array_sync.sv
// Addressed synchronous memory with cs/rd_wr access, registered read strobe and
// a clear sweep that zeroes every word after reset or on clr.
module ram_array_sync
    import ram_array_pkg::*;
#(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cs,
    input  logic              rd_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              ready
);

    ram_state_t        state;
    logic [ADDR_W-1:0] cnt;

    logic              in_range_c;
    logic              access_c;
    logic              user_we_c;
    logic              rd_acc_c;
    logic              clear_we_c;
    logic              we_c;
    logic [ADDR_W-1:0] waddr_c;
    logic [WIDTH-1:0]  wdata_c;
    logic [ADDR_W-1:0] raddr_c;

    // Access qualification; clr and rst both drop a same-cycle access.
    always_comb begin
        in_range_c = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
        access_c   = (state == IDLE) && cs && !clr && !rst;
        user_we_c  = access_c && !rd_wr && in_range_c;
        rd_acc_c   = access_c && rd_wr;
        clear_we_c = (state == CLEAR) && !rst;
        we_c       = clear_we_c || user_we_c;
        waddr_c    = clear_we_c ? cnt : addr;
        wdata_c    = clear_we_c ? '0 : wr_data;
        raddr_c    = in_range_c ? addr : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            ready    <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    rd_valid <= 1'b0;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    rd_valid <= rd_acc_c;
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state    <= CLEAR;
                    cnt      <= '0;
                    ready    <= 1'b0;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

    ram_core #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we      (we_c),
        .waddr   (waddr_c),
        .wdata   (wdata_c),
        .re      (rd_acc_c),
        .rzero   (!in_range_c),
        .raddr   (raddr_c),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ram_array_sync.sv
// Bench for ram_array_sync: a DEPTH=16 instance driven from a vector table and a read
// scoreboard, plus a DEPTH=10 instance for out-of-range addressing.
module tb_ram_array_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=16 instance
    logic       rst, clr, cs, rd_wr;
    logic [3:0] addr;
    logic [7:0] wr_data, rd_data;
    logic       rd_valid, ready;

    // DEPTH=10 instance
    logic       rst_b, clr_b, cs_b, rd_wr_b;
    logic [3:0] addr_b;
    logic [7:0] wr_data_b, rd_data_b;
    logic       rd_valid_b, ready_b;

    ram_array_sync #(.WIDTH(8), .DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .cs(cs), .rd_wr(rd_wr), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .ready(ready)
    );

    ram_array_sync #(.WIDTH(8), .DEPTH(10)) u_dut10 (
        .clk(clk), .rst(rst_b), .clr(clr_b), .cs(cs_b), .rd_wr(rd_wr_b), .addr(addr_b),
        .wr_data(wr_data_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .ready(ready_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    typedef struct {
        logic       cs;
        logic       rd_wr;
        logic [3:0] addr;
        logic [7:0] wr_data;
        logic [7:0] exp;
        logic       chk_hold;
    } vec_t;
    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Read results are due at the first negedge after the edge that samples the request.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("rd_valid_strobe", 32'(rd_valid), 32'd1);
                check("rd_data", 32'(rd_data), 32'(e.data));
            end else begin
                check("rd_valid_quiet", 32'(rd_valid), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        cs = 1'b1; rd_wr = 1'b1; addr = a;
        sb.push_back('{exp, cyc + 1});
        tick();
        cs = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; rd_wr = 1'b0; addr = a; wr_data = d;
        tick();
        cs = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int expn);
        int n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'(expn));
    endtask

    task automatic rd_b(input logic [3:0] a, input logic [7:0] exp);
        cs_b = 1'b1; rd_wr_b = 1'b1; addr_b = a;
        tick();
        cs_b = 1'b0;
        check("d10_rd_valid", 32'(rd_valid_b), 32'd1);
        check("d10_rd_data", 32'(rd_data_b), 32'(exp));
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [7:0] d);
        cs_b = 1'b1; rd_wr_b = 1'b0; addr_b = a; wr_data_b = d;
        tick();
        cs_b = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0; cs = 1'b0; rd_wr = 1'b0; addr = '0; wr_data = '0;
        rst_b = 1'b1; clr_b = 1'b0; cs_b = 1'b0; rd_wr_b = 1'b0; addr_b = '0; wr_data_b = '0;

        vt[0] = '{1'b1, 1'b0, 4'd3, 8'hA5, 8'h00, 1'b0};
        vt[1] = '{1'b1, 1'b0, 4'd4, 8'h5A, 8'h00, 1'b0};
        vt[2] = '{1'b1, 1'b1, 4'd3, 8'h00, 8'hA5, 1'b0};
        vt[3] = '{1'b1, 1'b1, 4'd4, 8'h00, 8'h5A, 1'b0};
        vt[4] = '{1'b0, 1'b1, 4'd3, 8'h00, 8'h5A, 1'b1};
        vt[5] = '{1'b0, 1'b0, 4'd0, 8'h00, 8'h5A, 1'b1};
        vt[6] = '{1'b1, 1'b0, 4'd7, 8'hFF, 8'h00, 1'b0};
        vt[7] = '{1'b1, 1'b1, 4'd7, 8'h00, 8'hFF, 1'b0};
        vt[8] = '{1'b0, 1'b0, 4'd0, 8'h00, 8'hFF, 1'b1};

        // Reset for two cycles, then the clear sweep.
        tick();
        mon_en = 1'b1;
        tick();
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        wait_ready("reset_clear_cycles", 16);
        for (int i = 0; i < 16; i++) rd(4'(i), 8'h00);

        // Table-driven write/read, hold and read-after-write.
        for (int i = 0; i < 9; i++) begin
            cs = vt[i].cs; rd_wr = vt[i].rd_wr; addr = vt[i].addr; wr_data = vt[i].wr_data;
            if (vt[i].cs && vt[i].rd_wr) sb.push_back('{vt[i].exp, cyc + 1});
            tick();
            if (vt[i].chk_hold) check("rd_data_hold", 32'(rd_data), 32'(vt[i].exp));
        end
        cs = 1'b0;

        // clr beats a same-cycle write; cs ignored during the sweep.
        wr(4'd2, 8'h22);
        rd(4'd2, 8'h22);
        check("ready_before_clr", 32'(ready), 32'd1);
        clr = 1'b1; cs = 1'b1; rd_wr = 1'b0; addr = 4'd2; wr_data = 8'h11;
        tick();
        clr = 1'b0; cs = 1'b0;
        check("ready_falls_on_clr", 32'(ready), 32'd0);
        cs = 1'b1; rd_wr = 1'b1; addr = 4'd2;
        tick();
        cs = 1'b0;
        wait_ready("clr_clear_cycles", 15);
        rd(4'd2, 8'h00);
        rd(4'd3, 8'h00);
        rd(4'd7, 8'h00);

        // Reset partway through a clr sweep restarts the count.
        for (int i = 0; i < 16; i++) wr(4'(i), 8'(i * 7 + 1));
        rd(4'd15, 8'd106);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_midclear_ready", 32'(ready), 32'd0);
        wait_ready("rst_midclear_cycles", 16);
        for (int i = 0; i < 16; i++) rd(4'(i), 8'h00);
        tick();

        // DEPTH=10: out-of-range writes discarded, reads return zero.
        tick();
        rst_b = 1'b0;
        n = 0;
        while (!ready_b && n < 200) begin
            tick();
            n++;
        end
        check("d10_clear_cycles", 32'(n), 32'd10);
        wr_b(4'd0, 8'h44);
        wr_b(4'd9, 8'h99);
        wr_b(4'd12, 8'h33);
        wr_b(4'd15, 8'h77);
        for (int i = 0; i < 10; i++)
            rd_b(4'(i), (i == 0) ? 8'h44 : ((i == 9) ? 8'h99 : 8'h00));
        rd_b(4'd12, 8'h00);
        rd_b(4'd15, 8'h00);
        tick();
        check("d10_rd_valid_drop", 32'(rd_valid_b), 32'd0);
        check("d10_rd_data_hold", 32'(rd_data_b), 32'd0);

        tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
